fp_operand_join_collector: RTL and testbench
============================================

Name: fp_operand_join_collector

Overview:
- Receive-side wrapper for the fixed-latency floating-point pipelines, such as the floating-point multiplier.
- Accepts two independent valid/ready operand streams (A and B), of the kind produced by the stream drivers, and pairs them one-for-one.
- Issues each pair to the pipeline, which has no backpressure, and collects the results into an output FIFO.
- Presents the results as a valid/ready stream, using credit-based admission so that no result can ever be dropped.

Parameters:
DATA_WIDTH, 32, width of operands and results
FIFO_DEPTH, 8, result FIFO entries and issue credits; power of two, >= 2

Ports:
clkIn  input  1  clock
rstIn  input  1  synchronous active-high reset
aDataIn  input  DATA_WIDTH  operand A data
aValidIn  input  1  operand A valid
aReadyOut  output  1  operand A ready
bDataIn  input  DATA_WIDTH  operand B data
bValidIn  input  1  operand B valid
bReadyOut  output  1  operand B ready
opADataOut  output  DATA_WIDTH  registered operand A to pipeline
opBDataOut  output  DATA_WIDTH  registered operand B to pipeline
opValidOut  output  1  operand pair valid to pipeline (single-cycle pulse per pair)
resDataIn  input  DATA_WIDTH  pipeline result
resValidIn  input  1  pipeline result valid
dataOut  output  DATA_WIDTH  FIFO head (show-ahead)
validOut  output  1  FIFO not empty
readyIn  input  1  downstream ready
countOut  output  clog2(FIFO_DEPTH+1)  FIFO occupancy
errorOut  output  1  sticky overflow flag

Behaviour:
- Clock and reset: single clock clkIn; rstIn is synchronous and active-high.
- Reset values:
  - opValidOut, validOut, errorOut, countOut are 0.
  - opADataOut, opBDataOut are 0.
  - FIFO pointers are 0; credits are FIFO_DEPTH.
- Join and admission:
  - creditOk = (credits != 0).
  - aReadyOut = bReadyOut = creditOk & aValidIn & bValidIn, combinational.
  - A transfer occurs on both streams in the same cycle or not at all; one stream is never consumed alone.
- Issue register:
  - On a transfer, opADataOut/opBDataOut capture aDataIn/bDataIn and opValidOut = 1 on the next cycle.
  - Otherwise opValidOut = 0 and the data registers hold.
  - Back-to-back transfers give a continuous opValidOut.
- Credits:
  - Decrement on transfer; increment on pop (validOut & readyIn).
  - When both occur in the same cycle, credits are unchanged.
  - Invariant: credits + in-flight + countOut = FIFO_DEPTH.
  - credits never exceeds FIFO_DEPTH and never underflows.
- Result FIFO:
  - Push on resValidIn; pop on validOut & readyIn.
  - No bypass: a push into an empty FIFO raises validOut on the next cycle.
  - Push and pop in the same cycle:
    - full: count stays FIFO_DEPTH, and the pushed data is written into the freed slot.
    - empty: push only.
  - Pointers wrap modulo FIFO_DEPTH; order is strictly preserved.
- Overflow:
  - resValidIn while full without a simultaneous pop: the result is dropped and errorOut = 1 from the next cycle until rstIn.
  - Unreachable when the pipeline honours its fixed latency.
- Reset mid-operation:
  - Clears FIFO, credits and issue register immediately.
  - The downstream pipeline shares rstIn, so no stale results arrive afterwards.
  - Any resValidIn arriving after reset is treated as a normal push.
- Latency:
  - Operand handshake to opValidOut: 1 cycle.
  - resValidIn to validOut: 1 cycle.

Test Plan:
1. Reset, with aValidIn=bValidIn=0 -> all outputs 0, aReadyOut=0; after releasing rstIn, the first transfer succeeds (credits=8).
2. A=0x40400000, B=0x40000000, readyIn=1, multiplier attached -> opValidOut high exactly one cycle after the handshake with those operands; dataOut=0x40C00000 with validOut for one cycle; countOut returns to 0.
3. readyIn=0, 12 pairs offered back-to-back -> exactly 8 transfers, then aReadyOut=bReadyOut=0; countOut=8, errorOut=0. Raise readyIn -> 8 results emerge in issue order, then the remaining 4 pairs are accepted.
4. aValidIn=1, bValidIn=0 for 5 cycles -> no transfer, both ready outputs 0, opValidOut=0. bValidIn rises -> exactly one transfer with the held A data.
5. FIFO full (count 8), readyIn=1 with resValidIn pulsed in the same cycle -> countOut stays 8, errorOut=0. Next, with readyIn=0, drive resValidIn=1 with 0xDEADBEEF -> value dropped, errorOut=1 and held until rstIn.
6. Assert rstIn for 1 cycle with 5 pairs in flight/FIFO -> validOut=0 and countOut=0 the next cycle; 8 credits restored (8 pairs accepted with readyIn=0).

Source files
------------

// File: rtl/fp_operand_join_collector_if.sv
// Handshake bundle for fp_operand_join_collector: two operand streams in, an
// operand pair out to a no-backpressure pipeline, its results in, and one result stream out.
interface fp_operand_join_collector_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] aDataIn;
  logic                  aValidIn;
  logic                  aReadyOut;
  logic [DATA_WIDTH-1:0] bDataIn;
  logic                  bValidIn;
  logic                  bReadyOut;
  logic [DATA_WIDTH-1:0] opADataOut;
  logic [DATA_WIDTH-1:0] opBDataOut;
  logic                  opValidOut;
  logic [DATA_WIDTH-1:0] resDataIn;
  logic                  resValidIn;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  validOut;
  logic                  readyIn;
  logic [CW-1:0]         countOut;
  logic                  errorOut;

  modport slave (
    input  aDataIn, aValidIn, bDataIn, bValidIn, resDataIn, resValidIn, readyIn,
    output aReadyOut, bReadyOut, opADataOut, opBDataOut, opValidOut,
           dataOut, validOut, countOut, errorOut
  );

  modport master (
    output aDataIn, aValidIn, bDataIn, bValidIn, resDataIn, resValidIn, readyIn,
    input  aReadyOut, bReadyOut, opADataOut, opBDataOut, opValidOut,
           dataOut, validOut, countOut, errorOut
  );
endinterface

// File: rtl/fp_operand_join_collector.sv
// Joins operand streams A and B into pairs for a fixed-latency FP pipeline and
// collects its results in a show-ahead FIFO, admitting pairs only against free FIFO credits.
module fp_operand_join_collector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic                        clkIn,
  input logic                        rstIn,
  fp_operand_join_collector_if.slave bus
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [CW-1:0]         credits_q, credits_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic                  op_valid_q, op_valid_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic credit_ok, xfer, pop, full, push;

  always_comb begin
    credit_ok = (credits_q != '0);
    xfer      = credit_ok & bus.aValidIn & bus.bValidIn;
    pop       = (count_q != '0) & bus.readyIn;
    full      = (count_q == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push      = bus.resValidIn & (~full | pop);

    op_valid_d = xfer;
    op_a_d     = xfer ? bus.aDataIn : op_a_q;
    op_b_d     = xfer ? bus.bDataIn : op_b_q;

    credits_d = credits_q;
    if (xfer && !pop) begin
      credits_d = credits_q - CW'(1);
    end else if (pop && !xfer && (credits_q != CW'(FIFO_DEPTH))) begin
      credits_d = credits_q + CW'(1);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    error_d  = error_q | (bus.resValidIn & full & ~pop);
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      credits_q  <= CW'(FIFO_DEPTH);
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      error_q    <= error_d;
    end
  end

  // When full, wr_ptr equals rd_ptr, so a push-with-pop lands in the slot being read out.
  always_ff @(posedge clkIn) begin
    if (!rstIn && push) begin
      mem_q[wr_ptr_q] <= bus.resDataIn;
    end
  end

  assign bus.aReadyOut  = xfer;
  assign bus.bReadyOut  = xfer;
  assign bus.opADataOut = op_a_q;
  assign bus.opBDataOut = op_b_q;
  assign bus.opValidOut = op_valid_q;
  assign bus.dataOut    = mem_q[rd_ptr_q];
  assign bus.validOut   = (count_q != '0);
  assign bus.countOut   = count_q;
  assign bus.errorOut   = error_q;
endmodule

// File: tb/tb_fp_operand_join_collector.sv
// Directed bench for fp_operand_join_collector with a 3-stage truncating FP
// multiplier model attached to the issue port and an injection path for results.
module tb_fp_operand_join_collector;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  fp_operand_join_collector_if #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) bus_if ();

  fp_operand_join_collector #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clkIn (clk),
    .rstIn (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Normal-number multiply, mantissa truncated (exact for the operands used here).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  logic [2:0]  pv;
  logic [31:0] pd0, pd1, pd2;
  logic        inj_v;
  logic [31:0] inj_d;

  always @(posedge clk) begin
    if (rst) begin
      pv <= 3'b000;
    end else begin
      pv  <= {pv[1:0], bus_if.opValidOut};
      pd0 <= fmul(bus_if.opADataOut, bus_if.opBDataOut);
      pd1 <= pd0;
      pd2 <= pd1;
    end
  end

  assign bus_if.resValidIn = pv[2] | inj_v;
  assign bus_if.resDataIn  = inj_v ? inj_d : pd2;

  function automatic logic [31:0] bval(input int i);
    logic [31:0] base;
    base = 32'h4100_0000;
    return base | (32'(i) << 16);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.aValidIn = 1'b0;
    bus_if.bValidIn = 1'b0;
    bus_if.aDataIn  = '0;
    bus_if.bDataIn  = '0;
    bus_if.readyIn  = 1'b0;
    inj_v           = 1'b0;
    inj_d           = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    #1;
    tests++; if (bus_if.opValidOut !== 1'b0) begin fails++; $display("FAIL reset_opvalid: got %b expected 0", bus_if.opValidOut); end
    tests++; if (bus_if.validOut !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus_if.validOut); end
    tests++; if (bus_if.errorOut !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", bus_if.errorOut); end
    tests++; if (bus_if.countOut !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus_if.countOut); end
    tests++; if (bus_if.opADataOut !== 32'h0) begin fails++; $display("FAIL reset_opa: got %h expected 0", bus_if.opADataOut); end
    tests++; if (bus_if.opBDataOut !== 32'h0) begin fails++; $display("FAIL reset_opb: got %h expected 0", bus_if.opBDataOut); end
    tests++; if (bus_if.aReadyOut !== 1'b0) begin fails++; $display("FAIL reset_aready: got %b expected 0", bus_if.aReadyOut); end
    rst = 1'b0;
    step();
    bus_if.aDataIn  = 32'h3F80_0000;
    bus_if.bDataIn  = 32'h3F80_0000;
    bus_if.aValidIn = 1'b1;
    bus_if.bValidIn = 1'b1;
    #1;
    tests++; if ((bus_if.aReadyOut !== 1'b1) || (bus_if.bReadyOut !== 1'b1)) begin fails++; $display("FAIL first_xfer_ready: got a=%b b=%b expected 1 1", bus_if.aReadyOut, bus_if.bReadyOut); end
    step();
    bus_if.aValidIn = 1'b0;
    bus_if.bValidIn = 1'b0;
    bus_if.readyIn  = 1'b1;
    #1;
    tests++; if (bus_if.opValidOut !== 1'b1) begin fails++; $display("FAIL first_xfer_opvalid: got %b expected 1", bus_if.opValidOut); end
    for (int k = 0; k < 20 && bus_if.validOut !== 1'b1; k++) step();
    tests++; if ((bus_if.validOut !== 1'b1) || (bus_if.dataOut !== 32'h3F80_0000)) begin fails++; $display("FAIL first_xfer_result: got valid=%b data=%h expected 1 3f800000", bus_if.validOut, bus_if.dataOut); end
    step();
    idle();
  endtask

  task automatic test_multiply();
    bus_if.readyIn  = 1'b1;
    bus_if.aDataIn  = 32'h4040_0000;
    bus_if.bDataIn  = 32'h4000_0000;
    bus_if.aValidIn = 1'b1;
    bus_if.bValidIn = 1'b1;
    #1;
    tests++; if (bus_if.aReadyOut !== 1'b1) begin fails++; $display("FAIL mul_ready: got %b expected 1", bus_if.aReadyOut); end
    step();
    bus_if.aValidIn = 1'b0;
    bus_if.bValidIn = 1'b0;
    #1;
    tests++; if ((bus_if.opValidOut !== 1'b1) || (bus_if.opADataOut !== 32'h4040_0000) || (bus_if.opBDataOut !== 32'h4000_0000)) begin
      fails++; $display("FAIL mul_issue: got v=%b a=%h b=%h expected 1 40400000 40000000", bus_if.opValidOut, bus_if.opADataOut, bus_if.opBDataOut);
    end
    step();
    #1;
    tests++; if (bus_if.opValidOut !== 1'b0) begin fails++; $display("FAIL mul_issue_pulse: got %b expected 0", bus_if.opValidOut); end
    for (int k = 0; k < 20 && bus_if.validOut !== 1'b1; k++) step();
    tests++; if ((bus_if.validOut !== 1'b1) || (bus_if.dataOut !== 32'h40C0_0000)) begin fails++; $display("FAIL mul_result: got valid=%b data=%h expected 1 40c00000", bus_if.validOut, bus_if.dataOut); end
    step();
    #1;
    tests++; if ((bus_if.validOut !== 1'b0) || (bus_if.countOut !== 4'd0)) begin fails++; $display("FAIL mul_drained: got valid=%b count=%0d expected 0 0", bus_if.validOut, bus_if.countOut); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    int acc;
    int rx;
    acc = 0;
    rx  = 0;
    bus_if.readyIn = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus_if.aDataIn  = 32'h3F80_0000;
      bus_if.bDataIn  = bval(acc);
      bus_if.aValidIn = (acc < 12);
      bus_if.bValidIn = (acc < 12);
      #1;
      if (bus_if.aReadyOut === 1'b1) begin
        exp_q.push_back(bval(acc));
        acc++;
      end
      step();
    end
    #1;
    tests++; if (acc != 8) begin fails++; $display("FAIL b2b_admitted: got %0d expected 8", acc); end
    tests++; if ((bus_if.aReadyOut !== 1'b0) || (bus_if.bReadyOut !== 1'b0)) begin fails++; $display("FAIL b2b_stalled: got a=%b b=%b expected 0 0", bus_if.aReadyOut, bus_if.bReadyOut); end
    tests++; if (bus_if.countOut !== 4'd8) begin fails++; $display("FAIL b2b_count: got %0d expected 8", bus_if.countOut); end
    tests++; if (bus_if.errorOut !== 1'b0) begin fails++; $display("FAIL b2b_error: got %b expected 0", bus_if.errorOut); end
    bus_if.readyIn = 1'b1;
    for (int c = 0; c < 200 && rx < 12; c++) begin
      bus_if.aDataIn  = 32'h3F80_0000;
      bus_if.bDataIn  = bval(acc);
      bus_if.aValidIn = (acc < 12);
      bus_if.bValidIn = (acc < 12);
      #1;
      if (bus_if.validOut === 1'b1) begin
        tests++;
        if (rx >= exp_q.size() || bus_if.dataOut !== exp_q[rx]) begin
          fails++; $display("FAIL b2b_order[%0d]: got %h expected %h", rx, bus_if.dataOut, (rx < exp_q.size()) ? exp_q[rx] : 32'hx);
        end
        rx++;
      end
      if (bus_if.aReadyOut === 1'b1) begin
        exp_q.push_back(bval(acc));
        acc++;
      end
      step();
    end
    tests++; if ((rx != 12) || (acc != 12)) begin fails++; $display("FAIL b2b_total: got rx=%0d acc=%0d expected 12 12", rx, acc); end
    idle();
    step();
    #1;
    tests++; if (bus_if.countOut !== 4'd0) begin fails++; $display("FAIL b2b_empty: got %0d expected 0", bus_if.countOut); end
  endtask

  task automatic test_partial_valid();
    bus_if.readyIn  = 1'b0;
    bus_if.aDataIn  = 32'h4040_0000;
    bus_if.aValidIn = 1'b1;
    bus_if.bValidIn = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if ((bus_if.aReadyOut !== 1'b0) || (bus_if.bReadyOut !== 1'b0) || (bus_if.opValidOut !== 1'b0)) begin
        fails++; $display("FAIL half_valid[%0d]: got a=%b b=%b op=%b expected 0 0 0", c, bus_if.aReadyOut, bus_if.bReadyOut, bus_if.opValidOut);
      end
      step();
    end
    bus_if.bDataIn  = 32'h4080_0000;
    bus_if.bValidIn = 1'b1;
    #1;
    tests++; if ((bus_if.aReadyOut !== 1'b1) || (bus_if.bReadyOut !== 1'b1)) begin fails++; $display("FAIL half_join_ready: got a=%b b=%b expected 1 1", bus_if.aReadyOut, bus_if.bReadyOut); end
    step();
    bus_if.aValidIn = 1'b0;
    bus_if.bValidIn = 1'b0;
    #1;
    tests++; if ((bus_if.opValidOut !== 1'b1) || (bus_if.opADataOut !== 32'h4040_0000) || (bus_if.opBDataOut !== 32'h4080_0000)) begin
      fails++; $display("FAIL half_join_issue: got v=%b a=%h b=%h expected 1 40400000 40800000", bus_if.opValidOut, bus_if.opADataOut, bus_if.opBDataOut);
    end
    step();
    #1;
    tests++; if (bus_if.opValidOut !== 1'b0) begin fails++; $display("FAIL half_join_single: got %b expected 0", bus_if.opValidOut); end
    bus_if.readyIn = 1'b1;
    for (int k = 0; k < 20 && bus_if.validOut !== 1'b1; k++) step();
    tests++; if ((bus_if.validOut !== 1'b1) || (bus_if.dataOut !== 32'h4140_0000)) begin fails++; $display("FAIL half_join_result: got valid=%b data=%h expected 1 41400000", bus_if.validOut, bus_if.dataOut); end
    step();
    idle();
  endtask

  task automatic test_full_overflow();
    logic [31:0] exp_q [$];
    int acc;
    int rx;
    acc = 0;
    rx  = 0;
    bus_if.readyIn = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus_if.aDataIn  = 32'h3F80_0000;
      bus_if.bDataIn  = bval(acc);
      bus_if.aValidIn = (acc < 8);
      bus_if.bValidIn = (acc < 8);
      #1;
      if (bus_if.aReadyOut === 1'b1) acc++;
      step();
    end
    bus_if.aValidIn = 1'b0;
    bus_if.bValidIn = 1'b0;
    #1;
    tests++; if (bus_if.countOut !== 4'd8) begin fails++; $display("FAIL full_count: got %0d expected 8", bus_if.countOut); end
    bus_if.readyIn = 1'b1;
    inj_d = 32'h1234_5678;
    inj_v = 1'b1;
    step();
    inj_v = 1'b0;
    bus_if.readyIn = 1'b0;
    #1;
    tests++; if ((bus_if.countOut !== 4'd8) || (bus_if.errorOut !== 1'b0)) begin fails++; $display("FAIL full_pushpop: got count=%0d err=%b expected 8 0", bus_if.countOut, bus_if.errorOut); end
    inj_d = 32'hDEAD_BEEF;
    inj_v = 1'b1;
    step();
    inj_v = 1'b0;
    #1;
    tests++; if ((bus_if.errorOut !== 1'b1) || (bus_if.countOut !== 4'd8)) begin fails++; $display("FAIL overflow_flag: got err=%b count=%0d expected 1 8", bus_if.errorOut, bus_if.countOut); end
    step();
    step();
    step();
    tests++; if (bus_if.errorOut !== 1'b1) begin fails++; $display("FAIL overflow_sticky: got %b expected 1", bus_if.errorOut); end
    for (int i = 1; i < 8; i++) exp_q.push_back(bval(i));
    exp_q.push_back(32'h1234_5678);
    bus_if.readyIn = 1'b1;
    for (int c = 0; c < 30 && rx < 8; c++) begin
      #1;
      if (bus_if.validOut === 1'b1) begin
        tests++;
        if (bus_if.dataOut !== exp_q[rx]) begin fails++; $display("FAIL full_drain[%0d]: got %h expected %h", rx, bus_if.dataOut, exp_q[rx]); end
        rx++;
      end
      step();
    end
    #1;
    tests++; if ((rx != 8) || (bus_if.validOut !== 1'b0)) begin fails++; $display("FAIL full_drain_total: got rx=%0d valid=%b expected 8 0", rx, bus_if.validOut); end
    tests++; if (bus_if.errorOut !== 1'b1) begin fails++; $display("FAIL overflow_after_drain: got %b expected 1", bus_if.errorOut); end
    idle();
  endtask

  task automatic test_reset_midstream();
    int acc;
    acc = 0;
    bus_if.readyIn = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus_if.aDataIn  = 32'h3F80_0000;
      bus_if.bDataIn  = bval(acc);
      bus_if.aValidIn = (acc < 5);
      bus_if.bValidIn = (acc < 5);
      #1;
      if (bus_if.aReadyOut === 1'b1) acc++;
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    tests++; if ((bus_if.validOut !== 1'b0) || (bus_if.countOut !== 4'd0)) begin fails++; $display("FAIL midreset_fifo: got valid=%b count=%0d expected 0 0", bus_if.validOut, bus_if.countOut); end
    tests++; if ((bus_if.opValidOut !== 1'b0) || (bus_if.errorOut !== 1'b0)) begin fails++; $display("FAIL midreset_regs: got op=%b err=%b expected 0 0", bus_if.opValidOut, bus_if.errorOut); end
    acc = 0;
    for (int c = 0; c < 25; c++) begin
      bus_if.aDataIn  = 32'h3F80_0000;
      bus_if.bDataIn  = bval(acc);
      bus_if.aValidIn = 1'b1;
      bus_if.bValidIn = 1'b1;
      #1;
      if (bus_if.aReadyOut === 1'b1) acc++;
      step();
    end
    #1;
    tests++; if (acc != 8) begin fails++; $display("FAIL midreset_credits: got %0d expected 8", acc); end
    tests++; if ((bus_if.countOut !== 4'd8) || (bus_if.aReadyOut !== 1'b0)) begin fails++; $display("FAIL midreset_refill: got count=%0d ready=%b expected 8 0", bus_if.countOut, bus_if.aReadyOut); end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_multiply();
    test_back_to_back();
    test_partial_valid();
    test_full_overflow();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
